// File: rtl/ddr_axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ddr_axi_pkg                                                     |
// | Desc     : Shared types and helpers for the DDR AXI read/write controllers |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package ddr_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

    // AXI burst length field is beats-minus-one.
    function automatic logic [7:0] burst_beats_m1(input int burst_bytes, input int data_width);
        int beats;
        beats = burst_bytes / (data_width / 8);
        return 8'(beats - 1);
    endfunction

    function automatic int slice_count(input int axi_width, input int user_width);
        return axi_width / user_width;
    endfunction

    localparam int c_rd_slices = slice_count(128, 16);

endpackage
`default_nettype wire

// File: rtl/rd_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rd_ctrl_if                                                      |
// | Desc     : AXI read-request/data and user read-port bundle for rd_ctrl     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface rd_ctrl_if #(
    parameter int USER_RD_DATA_WIDTH = 16,
    parameter int AXI_DATA_WIDTH     = 128,
    parameter int AXI_ADDR_WIDTH     = 32
);
    logic                          rd_req_en;
    logic                          rd_req_ack;
    logic [7:0]                    rd_burst_length;
    logic [AXI_ADDR_WIDTH-1:0]     rd_data_addr;
    logic [AXI_DATA_WIDTH-1:0]     rd_data_in;
    logic                          rd_data_valid;
    logic                          rd_data_last;
    logic                          rd_data_ready;
    logic [USER_RD_DATA_WIDTH-1:0] user_rd_data;
    logic                          user_rd_valid;
    logic                          user_rd_ready;

    // master is the read controller; slave is the AXI master plus the user consumer
    modport master (
        output rd_req_en, rd_burst_length, rd_data_addr, rd_data_ready,
               user_rd_data, user_rd_valid,
        input  rd_req_ack, rd_data_in, rd_data_valid, rd_data_last, user_rd_ready
    );

    modport slave (
        input  rd_req_en, rd_burst_length, rd_data_addr, rd_data_ready,
               user_rd_data, user_rd_valid,
        output rd_req_ack, rd_data_in, rd_data_valid, rd_data_last, user_rd_ready
    );
endinterface
`default_nettype wire

// File: rtl/rd_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rd_unpack                                                       |
// | Desc     : Splits each AXI read beat into user words, LSB slice first      |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rd_unpack
    import ddr_axi_pkg::*;
#(
    parameter int USER_RD_DATA_WIDTH = 16,
    parameter int AXI_DATA_WIDTH     = 128
) (
    input  wire logic                          clk,
    input  wire logic                          reset_n,
    input  wire logic                          i_active,
    input  wire logic [AXI_DATA_WIDTH-1:0]     i_beat,
    input  wire logic                          i_beat_valid,
    output logic                               o_beat_ready,
    output logic [USER_RD_DATA_WIDTH-1:0]      o_word,
    output logic                               o_word_valid,
    input  wire logic                          i_word_ready
);
    localparam int                c_slices     = slice_count(AXI_DATA_WIDTH, USER_RD_DATA_WIDTH);
    localparam int                c_cnt_w      = (c_slices > 1) ? $clog2(c_slices) : 1;
    localparam logic [c_cnt_w-1:0] c_last_slice = c_cnt_w'(c_slices - 1);

    generate
        if (AXI_DATA_WIDTH % USER_RD_DATA_WIDTH != 0) begin : g_bad_width
            $error("USER_RD_DATA_WIDTH must divide AXI_DATA_WIDTH");
        end
    endgenerate

    logic [AXI_DATA_WIDTH-1:0] r_buf;
    logic                      r_full;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      w_last_slice;
    logic                      w_load;
    logic                      w_shift;

    assign w_last_slice = (r_cnt == c_last_slice);
    // Accepting while the final slice drains keeps beats back-to-back.
    assign o_beat_ready = i_active && (!r_full || (i_word_ready && w_last_slice));
    assign w_load       = i_beat_valid && o_beat_ready;
    assign w_shift      = r_full && i_word_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf  <= '0;
            r_full <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_buf  <= i_beat;
            r_full <= 1'b1;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_buf <= r_buf >> USER_RD_DATA_WIDTH;
            if (w_last_slice) begin
                r_full <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_word       = r_buf[USER_RD_DATA_WIDTH-1:0];
    assign o_word_valid = r_full;

endmodule
`default_nettype wire

// File: rtl/rd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rd_ctrl                                                         |
// | Desc     : DDR read controller: circular-window burst requests + unpacking |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module rd_ctrl
    import ddr_axi_pkg::*;
#(
    parameter int USER_RD_DATA_WIDTH = 16,
    parameter int AXI_DATA_WIDTH     = 128,
    parameter int AXI_ADDR_WIDTH     = 32,
    parameter int RD_BURST_LENGTH    = 4096
) (
    input  wire logic                      clk,
    input  wire logic                      reset_n,
    input  wire logic                      ddr_init_done,
    input  wire logic                      user_rd_start,
    input  wire logic [AXI_ADDR_WIDTH-1:0] user_rd_base_addr,
    input  wire logic [AXI_ADDR_WIDTH-1:0] user_rd_end_addr,
    output logic                           rd_busy,
    rd_ctrl_if.master                      bus
);
    localparam logic [7:0]                c_beats_m1   = burst_beats_m1(RD_BURST_LENGTH, AXI_DATA_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] c_burst_step = AXI_ADDR_WIDTH'(RD_BURST_LENGTH);

    logic                      r_sync_meta;
    logic                      r_ddr_rd_enable;
    rd_state_e                 r_state;
    logic                      r_req_en;
    logic                      r_addr_loaded;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_burst_len;
    logic                      w_in_data;
    logic                      w_data_ready;
    logic                      w_beat_last;
    logic [AXI_ADDR_WIDTH-1:0] w_wrap_thresh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_meta     <= 1'b0;
            r_ddr_rd_enable <= 1'b0;
        end else begin
            r_sync_meta     <= ddr_init_done;
            r_ddr_rd_enable <= r_sync_meta;
        end
    end

    assign w_in_data     = (r_state == ST_DATA);
    assign w_beat_last   = bus.rd_data_valid && w_data_ready && bus.rd_data_last;
    assign w_wrap_thresh = user_rd_end_addr - c_burst_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_req_en      <= 1'b0;
            r_addr_loaded <= 1'b0;
            r_addr        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_ddr_rd_enable && user_rd_start) begin
                        r_state  <= ST_REQ;
                        r_req_en <= 1'b1;
                        // Later restarts resume where the window walk left off.
                        if (!r_addr_loaded) begin
                            r_addr        <= user_rd_base_addr;
                            r_addr_loaded <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.rd_req_ack) begin
                        r_req_en <= 1'b0;
                        r_state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_beat_last) begin
                        r_addr <= (r_addr >= w_wrap_thresh) ? user_rd_base_addr
                                                            : r_addr + c_burst_step;
                        if (user_rd_start && r_ddr_rd_enable) begin
                            r_state  <= ST_REQ;
                            r_req_en <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_req_en <= 1'b0;
                end
            endcase
        end
    end

    // Zero until calibration so the port reads all-zero while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_burst_len <= 8'd0;
        end else begin
            r_burst_len <= r_ddr_rd_enable ? c_beats_m1 : 8'd0;
        end
    end

    rd_unpack #(
        .USER_RD_DATA_WIDTH (USER_RD_DATA_WIDTH),
        .AXI_DATA_WIDTH     (AXI_DATA_WIDTH)
    ) u_unpack (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_active     (w_in_data),
        .i_beat       (bus.rd_data_in),
        .i_beat_valid (bus.rd_data_valid),
        .o_beat_ready (w_data_ready),
        .o_word       (bus.user_rd_data),
        .o_word_valid (bus.user_rd_valid),
        .i_word_ready (bus.user_rd_ready)
    );

    assign bus.rd_req_en       = r_req_en;
    assign bus.rd_burst_length = r_burst_len;
    assign bus.rd_data_addr    = r_addr;
    assign bus.rd_data_ready   = w_data_ready;
    assign rd_busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/rd_ctrl.md
Name: rd_ctrl

Overview:
- Read-side counterpart of the DDR write controller; sits between the user read port and the AXI read master.
- Issues fixed-length read burst requests over a circular address window [user_rd_base_addr, user_rd_end_addr).
- Accepts 128-bit AXI read beats and unpacks each into USER_RD_DATA_WIDTH words, LSB slice first, under a valid/ready handshake.
- Slice order mirrors the writer's packing order, so data written and read back keeps its original sequence.

Parameters:
- USER_RD_DATA_WIDTH, 16: user read word width; must divide AXI_DATA_WIDTH.
- AXI_DATA_WIDTH, 128: AXI read data width.
- AXI_ADDR_WIDTH, 32: address width.
- RD_BURST_LENGTH, 4096: bytes per burst; address step per burst.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  reset, asynchronous, active-low.
- ddr_init_done  in  1  DDR calibration done; asynchronous to clk.
- user_rd_start  in  1  level; while high, bursts are issued back-to-back.
- user_rd_base_addr  in  AXI_ADDR_WIDTH  window base.
- user_rd_end_addr  in  AXI_ADDR_WIDTH  window end (exclusive).
- rd_req_en  out  1  burst request; held until acknowledged.
- rd_req_ack  in  1  AXI master accepted the request.
- rd_burst_length  out  8  constant RD_BURST_LENGTH/(AXI_DATA_WIDTH/8)-1; 255 at defaults.
- rd_data_addr  out  AXI_ADDR_WIDTH  burst start address.
- rd_data_in  in  AXI_DATA_WIDTH  AXI read beat.
- rd_data_valid  in  1  beat valid.
- rd_data_last  in  1  final beat of the burst.
- rd_data_ready  out  1  this block can accept a beat.
- user_rd_data  out  USER_RD_DATA_WIDTH  unpacked word.
- user_rd_valid  out  1  user_rd_data valid.
- user_rd_ready  in  1  user consumes the word.
- rd_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset state (reset_n low, asynchronous): all outputs 0; FSM in IDLE; rd_data_addr = 0; buffer empty.
- ddr_init_done is synchronised through two flops; the synchronised signal is ddr_rd_enable.
- Reset mid-burst: state, address and buffer are cleared immediately. The controller does not drain outstanding AXI beats; draining is the AXI master's responsibility.
- FSM states: IDLE, REQ, DATA.
  - IDLE -> REQ when ddr_rd_enable && user_rd_start. On the first entry after reset, rd_data_addr loads user_rd_base_addr.
  - REQ: rd_req_en = 1. On rd_req_ack, rd_req_en drops in the next cycle and the FSM moves to DATA.
  - DATA: on an accepted beat (rd_data_valid && rd_data_ready && rd_data_last), the address advances.
    - If rd_data_addr >= user_rd_end_addr - RD_BURST_LENGTH, the address wraps to user_rd_base_addr.
    - Otherwise it becomes rd_data_addr + RD_BURST_LENGTH.
    - The FSM then goes to REQ if user_rd_start && ddr_rd_enable, else to IDLE.
  - user_rd_start falling mid-burst: the current burst completes; no further request is issued.
- Unpacking:
  - One AXI_DATA_WIDTH shift buffer, a full flag, and a slice counter rd_cnt running 0..N-1, where N = AXI_DATA_WIDTH/USER_RD_DATA_WIDTH (8 at defaults).
  - An accepted beat loads the buffer, sets full and clears rd_cnt.
  - user_rd_data = buffer[USER_RD_DATA_WIDTH-1:0]; user_rd_valid = full.
  - On user_rd_valid && user_rd_ready, the buffer shifts right by USER_RD_DATA_WIDTH and rd_cnt increments. When rd_cnt == N-1, full clears unless a new beat loads in the same cycle.
- rd_data_ready is combinational: (state == DATA) && (!full || (user_rd_ready && rd_cnt == N-1)).
  - Load takes priority over shift when both occur in the same cycle.
  - Sustained throughput: one beat per N cycles with no bubble when user_rd_ready is held high.
- Latency: the first user word is valid the cycle after the first beat is accepted.
- rd_data_last seen early or late relative to 256 beats: ignored for counting; rd_data_last alone ends the burst.
- All address arithmetic is unsigned at AXI_ADDR_WIDTH; overflow wraps.

Decomposition:
- Package ddr_axi_pkg holds:
  - FSM state enum (IDLE/REQ/DATA).
  - Function computing beats-minus-one from burst bytes and data width.
  - Slice-count constant.
- One natural sub-module: rd_unpack (shift buffer, full flag, rd_cnt, ready logic). The top level keeps the FSM, the synchroniser and the address generation.

Test Plan:
- Reset/idle: hold ddr_init_done=0 with user_rd_start=1 for 100 cycles -> rd_req_en stays 0; all outputs stay 0.
- Single burst: base=0x0, end=0x10000; start, ack after 3 cycles, then 256 beats carrying incrementing 16-bit patterns, user_rd_ready=1.
  - rd_data_addr = 0x0 and rd_burst_length = 255.
  - 2048 user words appear in order 0,1,2…; word 0 is beat0[15:0].
  - rd_data_ready is high 1 cycle in 8.
- Wrap-around: base=0x1000, end=0x4000 -> request addresses are 0x1000, 0x2000, 0x3000, 0x1000.
- Backpressure: randomly toggle user_rd_ready at 30% -> no word lost or duplicated; rd_data_ready never high while full with rd_cnt < 7.
- Stop mid-burst: drop user_rd_start at beat 100 -> burst completes through rd_data_last; FSM returns to IDLE; no new rd_req_en.
- Async reset at beat 50: assert reset_n=0 -> outputs clear without a clock edge; after release and restart, the first request address is base.
